// File: rtl/div_ctrl_pkg.sv
// Shared encodings and constants for the divider issue controller.
package div_ctrl_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOCAL     = 3'd1;
  localparam state_t ST_ISSUE     = 3'd2;
  localparam state_t ST_WAIT_BUSY = 3'd3;
  localparam state_t ST_WAIT_DONE = 3'd4;
  localparam state_t ST_RESP      = 3'd5;
  localparam state_t ST_DRAIN     = 3'd6;
  localparam state_t ST_CLR       = 3'd7;

  localparam logic [XLEN-1:0] INT64_MIN = 64'h8000_0000_0000_0000;
  localparam logic [31:0]     INT32_MIN = 32'h8000_0000;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Turns unsigned quotient/remainder magnitudes into the architectural result:
// sign restoration for signed ops, then sign-extension of the low word for W ops.
module div_sign_fix
  import div_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] q_mag,
  input  logic [XLEN-1:0] r_mag,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic            neg_q,
  input  logic            neg_r,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] q_signed;
  logic [XLEN-1:0] r_signed;
  logic [XLEN-1:0] picked;

  always_comb begin
    if (neg_q) begin
      q_signed = {XLEN{1'b0}} - q_mag;
    end else begin
      q_signed = q_mag;
    end
    if (neg_r) begin
      r_signed = {XLEN{1'b0}} - r_mag;
    end else begin
      r_signed = r_mag;
    end
    // op[1] selects the remainder forms (REM/REMU)
    if (op[1]) begin
      picked = r_signed;
    end else begin
      picked = q_signed;
    end
    if (word) begin
      result = sext32(picked[31:0]);
    end else begin
      result = picked;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequencer in front of the multi-cycle unsigned divider: resolves divide-by-zero
// and signed overflow locally, otherwise issues magnitudes and fixes up the result.
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_word,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             div_start,
  output logic             div_clr,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  input  logic [XLEN-1:0]  div_q,
  input  logic [XLEN-1:0]  div_r,
  input  logic             div_dbz,
  input  logic             div_ready
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             word_q, word_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             dbz_q, dbz_d;
  logic             err_q, err_d;
  logic             seen_q, seen_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             rerr_q, rerr_d;
  logic             start_q, start_d;
  logic             clr_q, clr_d;

  logic             accept, is_signed, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0]  a_ext, b_ext, mag_a, mag_b, min_val;
  logic [XLEN-1:0]  fix_q, fix_r, fix_out;

  always_comb begin
    is_signed = ~req_op[0];
    if (req_word && is_signed) begin
      a_ext = sext32(req_rs1[31:0]);
      b_ext = sext32(req_rs2[31:0]);
    end else if (req_word) begin
      a_ext = {32'd0, req_rs1[31:0]};
      b_ext = {32'd0, req_rs2[31:0]};
    end else begin
      a_ext = req_rs1;
      b_ext = req_rs2;
    end
    a_neg  = is_signed & a_ext[XLEN-1];
    b_neg  = is_signed & b_ext[XLEN-1];
    b_zero = (b_ext == {XLEN{1'b0}});
    if (req_word) begin
      min_val = sext32(INT32_MIN);
    end else begin
      min_val = INT64_MIN;
    end
    ovf = is_signed & (a_ext == min_val) & (b_ext == {XLEN{1'b1}});
    if (a_neg) begin
      mag_a = {XLEN{1'b0}} - a_ext;
    end else begin
      mag_a = a_ext;
    end
    if (b_neg) begin
      mag_b = {XLEN{1'b0}} - b_ext;
    end else begin
      mag_b = b_ext;
    end
    accept = (state_q == ST_IDLE) & req_valid & ready_q & ~flush;
  end

  // Local results reuse the fixup: overflow quotient is |MIN|, div-by-zero keeps q all-ones.
  always_comb begin
    if (state_q == ST_LOCAL && dbz_q) begin
      fix_q = {XLEN{1'b1}};
      fix_r = dvd_q;
    end else if (state_q == ST_LOCAL) begin
      fix_q = dvd_q;
      fix_r = {XLEN{1'b0}};
    end else begin
      fix_q = div_q;
      fix_r = div_r;
    end
  end

  div_sign_fix u_fix (
    .q_mag  (fix_q),
    .r_mag  (fix_r),
    .op     (op_q),
    .word   (word_q),
    .neg_q  (neg_q_q),
    .neg_r  (neg_r_q),
    .result (fix_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    word_d  = word_q;
    tag_d   = tag_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dbz_d   = dbz_q;
    err_d   = err_q;
    seen_d  = seen_q;
    wd_d    = wd_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = req_op;
          word_d  = req_word;
          tag_d   = req_tag;
          neg_q_d = (a_neg ^ b_neg) & ~b_zero;
          neg_r_d = a_neg;
          dbz_d   = b_zero;
          err_d   = 1'b0;
          dvd_d   = mag_a;
          dvs_d   = mag_b;
          if (b_zero || ovf) begin
            state_d = ST_LOCAL;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCAL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
          data_d  = fix_out;
        end
      end
      // start is already on the wire during ISSUE, so a flush here must drain
      ST_ISSUE: begin
        wd_d   = {WD_W{1'b0}};
        seen_d = 1'b0;
        if (flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (flush) begin
          state_d = ST_DRAIN;
          seen_d  = 1'b0;
        end else if (div_dbz) begin
          state_d = ST_CLR;
          err_d   = 1'b1;
          data_d  = {XLEN{1'b0}};
        end else if (!div_ready) begin
          state_d = ST_WAIT_DONE;
          wd_d    = {WD_W{1'b0}};
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (flush) begin
          state_d = ST_DRAIN;
          seen_d  = 1'b1;
          wd_d    = {WD_W{1'b0}};
        end else if (div_ready) begin
          state_d = ST_RESP;
          data_d  = fix_out;
        end else if (wd_q >= WD_W'(TIMEOUT)) begin
          state_d = ST_CLR;
          err_d   = 1'b1;
          data_d  = {XLEN{1'b0}};
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_DRAIN: begin
        seen_d = seen_q | ~div_ready;
        if (seen_q && div_ready) begin
          state_d = ST_IDLE;
        end else if (wd_q >= WD_W'(TIMEOUT)) begin
          state_d = ST_CLR;
          err_d   = 1'b0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_RESP: begin
        if (flush || resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_CLR: begin
        if (flush) begin
          err_d = 1'b0;
        end else begin
          err_d = err_q;
        end
        if (div_ready && err_d) begin
          state_d = ST_RESP;
        end else if (div_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
    rerr_d  = (state_d == ST_RESP) & err_d;
    start_d = (state_d == ST_ISSUE);
    clr_d   = (state_d == ST_CLR) & (state_q != ST_CLR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      word_q  <= 1'b0;
      tag_q   <= {TAG_W{1'b0}};
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dbz_q   <= 1'b0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
      wd_q    <= {WD_W{1'b0}};
      dvd_q   <= {XLEN{1'b0}};
      dvs_q   <= {XLEN{1'b0}};
      data_q  <= {XLEN{1'b0}};
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rerr_q  <= 1'b0;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      tag_q   <= tag_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dbz_q   <= dbz_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      wd_q    <= wd_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rerr_q  <= rerr_d;
      start_q <= start_d;
      clr_q   <= clr_d;
    end
  end

  assign req_ready    = ready_q;
  assign resp_valid   = valid_q;
  assign resp_data    = data_q;
  assign resp_tag     = tag_q;
  assign resp_err     = rerr_q;
  assign div_start    = start_q;
  assign div_clr      = clr_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural multi-cycle divider model.
module tb_div_issue_ctrl;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;
  localparam int LAT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic        req_word = 1'b0;
  logic [63:0] req_rs1 = 64'd0;
  logic [63:0] req_rs2 = 64'd0;
  logic [4:0]  req_tag = 5'd0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_err;
  logic        div_start, div_clr;
  logic [63:0] div_dividend, div_divisor;
  logic [63:0] m_q, m_r, m_a, m_b;
  logic        m_ready;
  logic        div_dbz;
  int          m_cnt;
  logic        stuck = 1'b0;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int clr_cnt = 0;

  assign div_dbz = 1'b0;

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err),
    .div_start(div_start), .div_clr(div_clr),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_q(m_q), .div_r(m_r), .div_dbz(div_dbz), .div_ready(m_ready)
  );

  // Divider model: busy for LAT cycles after start, or forever when stuck; clr forces idle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
      m_q     <= 64'd0;
      m_r     <= 64'd0;
      m_a     <= 64'd0;
      m_b     <= 64'd0;
    end else if (div_clr) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
    end else if (div_start && m_ready) begin
      m_ready <= 1'b0;
      m_cnt   <= LAT;
      m_a     <= div_dividend;
      m_b     <= div_divisor;
    end else if (!m_ready && !stuck) begin
      if (m_cnt == 1) begin
        m_ready <= 1'b1;
        m_q     <= (m_b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : m_a / m_b;
        m_r     <= (m_b == 64'd0) ? m_a : m_a % m_b;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (div_start) start_cnt <= start_cnt + 1;
    if (div_clr) clr_cnt <= clr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] tag);
    int n;
    n = 0;
    req_op = op; req_word = w; req_rs1 = a; req_rs2 = b; req_tag = tag;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b expected 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic get_resp(output logic [63:0] d, output logic [4:0] t, output logic e,
                          output int cyc);
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid=%b expected 1", resp_valid);
    end
    d = resp_data; t = resp_tag; e = resp_err;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({req_ready, resp_valid, resp_err, div_start, div_clr} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 10000",
               {req_ready, resp_valid, resp_err, div_start, div_clr});
    end
    checks++;
    if ({resp_data, resp_tag, div_dividend, div_divisor} !== {197{1'b0}}) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h/%h expected zeros",
               resp_data, resp_tag, div_dividend, div_divisor);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_signed_div();
    logic [63:0] d; logic [4:0] t; logic e; int cyc, s0;
    s0 = start_cnt;
    send(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_m7_2: got %h expected fffffffffffffffd", d); end
    checks++;
    if ({t, e} !== {5'd3, 1'b0}) begin errors++; $display("FAIL div_tag_err: got %h/%b expected 03/0", t, e); end
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL div_starts: got %0d expected 1", start_cnt - s0); end
    checks++;
    if (cyc + 1 > 72) begin errors++; $display("FAIL div_latency: got %0d expected <= 72", cyc + 1); end
    ack();
    send(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_m7_2: got %h expected ffffffffffffffff", d); end
    ack();
    send(REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd5);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'd1) begin errors++; $display("FAIL rem_7_m2: got %h expected 1", d); end
    ack();
    send(DIV, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd6);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_7_m2: got %h expected fffffffffffffffd", d); end
    ack();
  endtask

  task automatic test_div_zero();
    logic [63:0] d; logic [4:0] t; logic e; int cyc, s0;
    s0 = start_cnt;
    send(DIVU, 1'b0, 64'd100, 64'd0, 5'd7);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divu_dbz: got %h expected ffffffffffffffff", d); end
    checks++;
    if (cyc + 1 != 2) begin errors++; $display("FAIL dbz_latency: got %0d expected 2", cyc + 1); end
    ack();
    send(REMU, 1'b0, 64'd100, 64'd0, 5'd8);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'd100) begin errors++; $display("FAIL remu_dbz: got %h expected 64", d); end
    ack();
    send(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd9);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div_neg_dbz: got %h expected ffffffffffffffff", d); end
    ack();
    send(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd10);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("FAIL rem_neg_dbz: got %h expected fffffffffffffffb", d); end
    ack();
    checks++;
    if (start_cnt != s0) begin errors++; $display("FAIL dbz_no_start: got %0d starts expected 0", start_cnt - s0); end
  endtask

  task automatic test_overflow();
    logic [63:0] d; logic [4:0] t; logic e; int cyc, s0;
    s0 = start_cnt;
    send(DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL div_ovf: got %h expected 8000000000000000", d); end
    checks++;
    if (cyc + 1 != 2) begin errors++; $display("FAIL ovf_latency: got %0d expected 2", cyc + 1); end
    ack();
    send(REM, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'd0) begin errors++; $display("FAIL remw_ovf: got %h expected 0", d); end
    ack();
    send(DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL divw_ovf: got %h expected ffffffff80000000", d); end
    ack();
    checks++;
    if (start_cnt != s0) begin errors++; $display("FAIL ovf_no_start: got %0d starts expected 0", start_cnt - s0); end
  endtask

  task automatic test_word();
    logic [63:0] d; logic [4:0] t; logic e; int cyc;
    send(DIV, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd4, 5'd14);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'd4) begin errors++; $display("FAIL divw_trunc: got %h expected 4", d); end
    ack();
    send(DIV, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd2, 5'd15);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL divw_neg: got %h expected fffffffffffffff8", d); end
    ack();
    send(DIVU, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd2, 5'd16);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'h0000_0000_7FFF_FFF8) begin errors++; $display("FAIL divuw: got %h expected 7ffffff8", d); end
    ack();
  endtask

  task automatic test_flush();
    logic [63:0] d; logic [4:0] t; logic e; int cyc, n; logic saw_valid;
    send(DIVU, 1'b0, 64'd1000, 64'd7, 5'd17);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({req_ready, m_ready} !== 2'b00) begin
      errors++; $display("FAIL flush_drain: req_ready/div_ready got %b expected 00", {req_ready, m_ready});
    end
    saw_valid = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 150) begin
      if (resp_valid === 1'b1) saw_valid = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (saw_valid !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL flush_resp: resp_valid seen expected none"); end
    checks++;
    if ({req_ready, m_ready} !== 2'b11) begin
      errors++; $display("FAIL flush_recover: req_ready/div_ready got %b expected 11", {req_ready, m_ready});
    end
    send(DIVU, 1'b0, 64'd1000, 64'd7, 5'd18);
    get_resp(d, t, e, cyc);
    checks++;
    if ({d, t} !== {64'd142, 5'd18}) begin errors++; $display("FAIL after_flush: got %h/%h expected 8e/12", d, t); end
    ack();
  endtask

  task automatic test_backpressure();
    logic [63:0] d; logic [4:0] t; logic e; int cyc;
    send(DIV, 1'b0, 64'd100, 64'd7, 5'd9);
    get_resp(d, t, e, cyc);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid, req_ready, resp_tag, resp_data} !== {1'b1, 1'b0, 5'd9, 64'd14}) begin
        errors++;
        $display("FAIL hold_%0d: v/rdy/tag/data got %b/%b/%h/%h expected 1/0/09/e", i,
                 resp_valid, req_ready, resp_tag, resp_data);
      end
      tick();
    end
    ack();
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL after_ack: got %b expected 01", {resp_valid, req_ready}); end
  endtask

  task automatic test_timeout();
    logic [63:0] d; logic [4:0] t; logic e; int cyc, c0;
    stuck = 1'b1;
    c0 = clr_cnt;
    send(DIVU, 1'b0, 64'd10, 64'd3, 5'd7);
    get_resp(d, t, e, cyc);
    checks++;
    if ({e, d, t} !== {1'b1, 64'd0, 5'd7}) begin errors++; $display("FAIL timeout_resp: err/data/tag got %b/%h/%h expected 1/0/07", e, d, t); end
    checks++;
    if (cyc + 1 < 100) begin errors++; $display("FAIL timeout_wait: got %0d cycles expected >= 100", cyc + 1); end
    checks++;
    if (clr_cnt - c0 != 1) begin errors++; $display("FAIL timeout_clr: got %0d pulses expected 1", clr_cnt - c0); end
    ack();
    stuck = 1'b0;
    send(DIVU, 1'b0, 64'd10, 64'd3, 5'd2);
    get_resp(d, t, e, cyc);
    checks++;
    if ({e, d} !== {1'b0, 64'd3}) begin errors++; $display("FAIL post_timeout: err/data got %b/%h expected 0/3", e, d); end
    ack();
  endtask

  task automatic test_mid_reset();
    logic [63:0] d; logic [4:0] t; logic e; int cyc;
    send(DIVU, 1'b0, 64'd50, 64'd5, 5'd1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({req_ready, resp_valid, div_start} !== 3'b100) begin
      errors++; $display("FAIL mid_reset: got %b expected 100", {req_ready, resp_valid, div_start});
    end
    rst = 1'b0;
    tick();
    send(DIVU, 1'b0, 64'd50, 64'd5, 5'd1);
    get_resp(d, t, e, cyc);
    checks++;
    if (d !== 64'd10) begin errors++; $display("FAIL after_reset: got %h expected a", d); end
    ack();
  endtask

  initial begin
    test_reset();
    test_signed_div();
    test_div_zero();
    test_overflow();
    test_word();
    test_flush();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
